mmix_dmem_responder: RTL
========================

Name: mmix_dmem_responder

Overview:
- Responder end of the execution-unit data-memory handshake: mem_address, mem_datasize, mem_read, mem_write, mem_writedata, mem_readdata, mem_done.
- Serves each request against a 32-bit Avalon-MM master port (on-chip RAM or SDRAM controller).
- Handles MMIX big-endian sizing and alignment, byte-enable generation, and splitting an octa into two tetra beats.
- Sits between the exec unit and the system interconnect; one request outstanding at a time.

Parameters:
- ADDR_W, 32, number of physical byte-address bits forwarded to Avalon; mem_address[63:ADDR_W] is ignored (translation happens upstream).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- mem_address  in  64  MMIX byte address of the request
- mem_datasize  in  2  0 byte, 1 wyde, 2 tetra, 3 octa
- mem_read  in  1  read request level, held until mem_done
- mem_write  in  1  write request level, held until mem_done
- mem_writedata  in  64  store data, right-justified
- mem_readdata  out  64  load data, right-justified, zero-extended
- mem_done  out  1  one-cycle completion pulse
- avm_address  out  ADDR_W  word-aligned byte address
- avm_byteenable  out  4  lane enables
- avm_read  out  1  Avalon read command
- avm_write  out  1  Avalon write command
- avm_writedata  out  32  Avalon write data
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  Avalon read data
- avm_readdatavalid  in  1  pipelined read return

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (reset_n). While reset_n=0, all outputs and registers are 0 and the state is S_IDLE.
- Reset mid-operation:
  - The Avalon command is dropped at once.
  - A late avm_readdatavalid seen in S_IDLE is ignored.
- Acceptance: a request is accepted only in S_IDLE, on the first cycle where mem_read or mem_write is 1.
  - If both are 1, read wins.
  - At acceptance, latch the aligned address, size, direction and write data. Later changes on the inputs are ignored until mem_done.
- Alignment (MMIX rule): clear low address bits before use:
  - byte: none
  - wyde: bit 0
  - tetra: bits 1:0
  - octa: bits 2:0
- Lane mapping: each Avalon word holds a tetra as its numeric value.
  - MMIX byte offset k (0..3) within the tetra maps to bits [31-8k -: 8] and byteenable bit 3-k.
  - Wyde at offset 0 uses enables 1100; at offset 2 it uses 0011.
  - Octa: high tetra at A (beat 0), low tetra at A+4 (beat 1), both with byteenable 1111.
- Write data: taken from the low bytes of the latched mem_writedata and replicated into the selected lanes.
- Read data: the selected lanes are right-justified into mem_readdata. Unused upper bits are 0; sign extension is done by the initiator.
- State machine:
  - S_IDLE -> S_CMD on accept; beat counter = 0.
  - S_CMD: drive avm_read or avm_write with the address and enables for the current beat.
    - Hold the command while avm_waitrequest=1.
    - When waitrequest=0: a write goes to S_NEXT; a read goes to S_RDWAIT.
  - S_RDWAIT: wait for avm_readdatavalid, capture avm_readdata into the high or low half, then go to S_NEXT.
  - S_NEXT: if octa and beat=0, set beat=1, address+4, and go to S_CMD. Otherwise go to S_DONE.
  - S_DONE: mem_done=1 for exactly this cycle; mem_readdata is stable. Go to S_IDLE.
- Handshake hazard: during the S_DONE cycle the initiator may still hold mem_read, or may already raise mem_write (compare-and-swap write-back). These levels are not sampled in S_DONE. The earliest next acceptance is the following cycle, in S_IDLE.
- Latency with zero wait states and read data the cycle after command acceptance:
  - write: mem_done 3 cycles after acceptance
  - read: 4 cycles
  - octa: one extra beat (+2 for write, +3 for read)
- mem_readdata: holds its value until the next read completes; it is not changed by writes.

Decomposition:
- mmix_defs package:
  - add datasize localparams DS_BYTE/DS_WYDE/DS_TETRA/DS_OCTA
  - add the state enum type for this block
- One combinational sub-module, dmem_lane_align, holds the lane logic:
  - inputs: address offset, size, write data, Avalon readdata
  - outputs: byteenable, lane-placed writedata, right-justified read value
  - it is instantiated once and used by both directions.

Test Plan:
- Byte write then read: write addr 0x1003, size 0, data 0xAB. Required: avm_address 0x1000, byteenable 0001, writedata[7:0]=0xAB. Read back gives mem_readdata 0x00000000000000AB.
- Octa read: addr 0x2005 aligns to 0x2000. Slave returns 0x01234567 then 0x89ABCDEF at 0x2004. Required: mem_readdata 0x0123456789ABCDEF, mem_done 1 cycle.
- Wyde write with avm_waitrequest held 3 cycles: addr 0x3003 gives avm_address 0x3000 and byteenable 0011. The command is held steady while stalled, and mem_done is delayed by exactly 3 cycles.
- Compare-and-swap pattern: read 0x4000 (octa), then mem_write rises in the mem_done cycle. Required: no command issued in the S_DONE cycle; the write is accepted the next cycle and completes.
- Reset during S_RDWAIT: assert reset_n=0, then release, then send a stray readdatavalid. Required: all outputs 0, mem_done never pulses, and the next tetra read 0x5000 returns correct data.

Source files
------------

// File: rtl/mmix_dmem_responder_pkg.sv
// Shared definitions for the MMIX data-memory responder: access sizes, FSM states
// and the MMIX natural-alignment helper.
package mmix_defs;

   localparam logic [1:0] DS_BYTE  = 2'd0;
   localparam logic [1:0] DS_WYDE  = 2'd1;
   localparam logic [1:0] DS_TETRA = 2'd2;
   localparam logic [1:0] DS_OCTA  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_RDWAIT,
      S_NEXT,
      S_DONE
   } dmem_state_e;

   // MMIX ignores the low address bits that fall inside the access size.
   function automatic logic [63:0] align_addr(input logic [63:0] addr, input logic [1:0] size);
      logic [63:0] mask;
      mask = (64'd1 << size) - 64'd1;
      return addr & ~mask;
   endfunction

endpackage

// File: rtl/mmix_dmem_responder_lane_align.sv
// Big-endian lane steering between one MMIX access (byte/wyde/tetra) and a 32-bit
// Avalon word: byte enables, lane-replicated store data and right-justified load data.
module dmem_lane_align
   import mmix_defs::*;
(
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  byteenable,
   output logic [31:0] lane_wdata,
   output logic [31:0] rdata_rj
);

   logic [31:0] byte_shift;

   always_comb begin
      byteenable = 4'b1111;
      lane_wdata = wdata;
      rdata_rj   = rdata;
      // byte k of the tetra sits at bits [31-8k -: 8]; ~offset equals 3-k
      byte_shift = rdata >> {~offset, 3'b000};
      case (size)
         DS_BYTE: begin
            byteenable = 4'b1000 >> offset;
            lane_wdata = {4{wdata[7:0]}};
            rdata_rj   = {24'd0, byte_shift[7:0]};
         end
         DS_WYDE: begin
            byteenable = offset[1] ? 4'b0011 : 4'b1100;
            lane_wdata = {2{wdata[15:0]}};
            rdata_rj   = {16'd0, (offset[1] ? rdata[15:0] : rdata[31:16])};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mmix_dmem_responder.sv
// Responder for the exec-unit data-memory handshake; serves one request at a time
// over a 32-bit Avalon-MM master, splitting octas into high/low tetra beats.
//
//   state    | meaning
//   S_IDLE   | waiting for mem_read/mem_write, latches the request
//   S_CMD    | Avalon command driven, held while waitrequest
//   S_RDWAIT | read issued, waiting for readdatavalid
//   S_NEXT   | advance to second octa beat or finish
//   S_DONE   | mem_done pulse, request levels not sampled
module mmix_dmem_responder
   import mmix_defs::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [63:0]       mem_address,
   input  logic [1:0]        mem_datasize,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [63:0]       mem_writedata,
   output logic [63:0]       mem_readdata,
   output logic              mem_done,
   output logic [ADDR_W-1:0] avm_address,
   output logic [3:0]        avm_byteenable,
   output logic              avm_read,
   output logic              avm_write,
   output logic [31:0]       avm_writedata,
   input  logic              avm_waitrequest,
   input  logic [31:0]       avm_readdata,
   input  logic              avm_readdatavalid
);

   dmem_state_e       state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        size_q;
   logic              is_rd_q;
   logic              beat_q;
   logic [63:0]       wdata_q;
   logic [31:0]       rd_hi_q;
   logic [63:0]       readdata_q;
   logic [63:0]       addr_al;
   logic              first_octa_beat;
   logic [31:0]       beat_wdata;
   logic [3:0]        lane_be;
   logic [31:0]       lane_wd;
   logic [31:0]       lane_rd;
   logic              unused_addr_hi;

   assign addr_al         = align_addr(mem_address, mem_datasize);
   assign unused_addr_hi  = ^addr_al[63:ADDR_W];
   assign first_octa_beat = (size_q == DS_OCTA) && !beat_q;
   assign beat_wdata      = first_octa_beat ? wdata_q[63:32] : wdata_q[31:0];
   assign mem_readdata    = readdata_q;

   dmem_lane_align u_lane (
      .offset     (addr_q[1:0]),
      .size       (size_q),
      .wdata      (beat_wdata),
      .rdata      (avm_readdata),
      .byteenable (lane_be),
      .lane_wdata (lane_wd),
      .rdata_rj   (lane_rd)
   );

   always_comb begin
      state_d        = state_q;
      mem_done       = 1'b0;
      avm_read       = 1'b0;
      avm_write      = 1'b0;
      avm_address    = '0;
      avm_byteenable = '0;
      avm_writedata  = '0;
      case (state_q)
         S_IDLE: if (mem_read || mem_write) state_d = S_CMD;
         S_CMD: begin
            avm_read       = is_rd_q;
            avm_write      = !is_rd_q;
            avm_address    = {addr_q[ADDR_W-1:2], 2'b00};
            avm_byteenable = lane_be;
            avm_writedata  = is_rd_q ? 32'd0 : lane_wd;
            if (!avm_waitrequest) state_d = is_rd_q ? S_RDWAIT : S_NEXT;
         end
         S_RDWAIT: if (avm_readdatavalid) state_d = S_NEXT;
         S_NEXT:   state_d = first_octa_beat ? S_CMD : S_DONE;
         S_DONE: begin
            mem_done = 1'b1;
            state_d  = S_IDLE;
         end
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         size_q     <= '0;
         is_rd_q    <= 1'b0;
         beat_q     <= 1'b0;
         wdata_q    <= '0;
         rd_hi_q    <= '0;
         readdata_q <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: if (mem_read || mem_write) begin
               addr_q  <= addr_al[ADDR_W-1:0];
               size_q  <= mem_datasize;
               is_rd_q <= mem_read;
               wdata_q <= mem_writedata;
               beat_q  <= 1'b0;
            end
            // octa high half is staged so mem_readdata only changes at completion
            S_RDWAIT: if (avm_readdatavalid) begin
               if (first_octa_beat)        rd_hi_q    <= avm_readdata;
               else if (size_q == DS_OCTA) readdata_q <= {rd_hi_q, avm_readdata};
               else                        readdata_q <= {32'd0, lane_rd};
            end
            S_NEXT: if (first_octa_beat) begin
               beat_q <= 1'b1;
               addr_q <= addr_q + ADDR_W'(4);
            end
            default: ;
         endcase
      end
   end

endmodule
